// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line/parity constants
// used by both the transmit and receive paths.
`default_nettype none

package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..Prescale-1 while running and flags the
// last cycle of each bit; same counting rules as the receiver's edge counter.
`default_nettype none

module uart_tx_bit_timer #(
   parameter int Prescale_Width = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [Prescale_Width-1:0] Prescale,
   input  logic                      run,
   output logic [Prescale_Width-1:0] edge_cnt,
   output logic                      bit_done
);

   localparam logic [Prescale_Width-1:0] ONE = Prescale_Width'(1);

   // Prescale is the latched, already non-zero value, so Prescale-1 never wraps.
   assign bit_done = run && (edge_cnt == (Prescale - ONE));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt <= '0;
      end else if (!run || bit_done) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a parallel word on handshake and shifts out
// start, LSB-first data, optional parity and stop bits at Prescale cycles/bit.
`default_nettype none

module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int Prescale_Width = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [Prescale_Width-1:0] Prescale,
   output logic                      TX_OUT,
   output logic                      busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [2:0]                state;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      par_en_q;
   logic                      par_typ_q;
   logic [Prescale_Width-1:0] prescale_q;
   logic [IDX_W-1:0]          bit_idx;
   logic [IDX_W-1:0]          next_idx;
   logic                      tx_q;
   logic                      busy_q;
   logic                      run;
   logic                      bit_done;
   logic                      parity_bit;
   logic [Prescale_Width-1:0] edge_cnt_unused;

   assign run        = (state != ST_IDLE);
   assign next_idx   = bit_idx + IDX_ONE;
   assign parity_bit = (par_typ_q == PAR_ODD) ? ~^data_q : ^data_q;
   assign TX_OUT     = tx_q;
   assign busy       = busy_q;

   uart_tx_bit_timer #(
      .Prescale_Width (Prescale_Width)
   ) u_bit_timer (
      .CLK      (CLK),
      .RST      (RST),
      .Prescale (prescale_q),
      .run      (run),
      .edge_cnt (edge_cnt_unused),
      .bit_done (bit_done)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         prescale_q <= Prescale_Width'(1);
         bit_idx    <= '0;
         tx_q       <= LINE_IDLE;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_q    <= LINE_IDLE;
               busy_q  <= 1'b0;
               bit_idx <= '0;
               if (Data_Valid) begin
                  data_q     <= P_DATA;
                  par_en_q   <= PAR_EN;
                  par_typ_q  <= PAR_TYP;
                  // A zero prescale would never complete a bit; run it as one cycle.
                  prescale_q <= (Prescale == '0) ? Prescale_Width'(1) : Prescale;
                  state      <= ST_START;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
                  tx_q    <= data_q[0];
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  if (bit_idx == LAST_IDX) begin
                     if (par_en_q) begin
                        state <= ST_PARITY;
                        tx_q  <= parity_bit;
                     end else begin
                        state <= ST_STOP;
                        tx_q  <= LINE_IDLE;
                     end
                  end else begin
                     bit_idx <= next_idx;
                     tx_q    <= data_q[next_idx];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  state <= ST_STOP;
                  tx_q  <= LINE_IDLE;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               tx_q   <= LINE_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer with hand-computed frames.
`default_nettype none

module tb_uart_tx_serializer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd0;
   logic       TX_OUT;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   uart_tx_serializer #(
      .DATA_WIDTH     (8),
      .Prescale_Width (6)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // bits holds the frame in transmission order: bits[0] is the start bit.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic [5:0] p,
                            input logic pe, input logic pt, input logic [11:0] bits,
                            input int nbits, input int cyc_per_bit, input bit hold_valid,
                            input int inject_at);
      int cyc;
      P_DATA     = d;
      Prescale   = p;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      if (!hold_valid) Data_Valid = 1'b0;
      cyc = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < cyc_per_bit; c++) begin
            if (inject_at >= 0 && cyc == inject_at) begin
               Data_Valid = 1'b1;
               P_DATA     = 8'h3C;
               Prescale   = 6'd2;
               PAR_EN     = 1'b0;
               PAR_TYP    = 1'b1;
            end else if (inject_at >= 0 && cyc == inject_at + 1) begin
               Data_Valid = 1'b0;
            end
            check($sformatf("%s tx b%0d c%0d", tag, b, c), TX_OUT, bits[b]);
            check($sformatf("%s busy b%0d c%0d", tag, b, c), busy, 1'b1);
            cyc++;
            @(negedge CLK);
         end
      end
      check($sformatf("%s idle_busy", tag), busy, 1'b0);
      check($sformatf("%s idle_tx", tag), TX_OUT, 1'b1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge CLK);
      check("reset_tx", TX_OUT, 1'b1);
      check("reset_busy", busy, 1'b0);
      RST = 1'b1;
      @(negedge CLK);
      check("post_reset_tx", TX_OUT, 1'b1);
      check("post_reset_busy", busy, 1'b0);

      // A5, even parity, 8 cycles/bit: {stop, par, data, start}
      run_frame("t1_a5", 8'hA5, 6'd8, 1'b1, 1'b0, 12'b0_1_0_10100101_0, 11, 8, 1'b0, -1);

      // Odd parity: 01 -> parity 0, 00 -> parity 1
      run_frame("t2_01", 8'h01, 6'd4, 1'b1, 1'b1, 12'b0_1_0_00000001_0, 11, 4, 1'b0, -1);
      run_frame("t2_00", 8'h00, 6'd4, 1'b1, 1'b1, 12'b0_1_1_00000000_0, 11, 4, 1'b0, -1);

      // No parity
      run_frame("t3_ff", 8'hFF, 6'd4, 1'b0, 1'b0, 12'b00_1_11111111_0, 10, 4, 1'b0, -1);

      // Request and input changes mid-frame are ignored
      run_frame("t4_a5", 8'hA5, 6'd8, 1'b1, 1'b0, 12'b0_1_0_10100101_0, 11, 8, 1'b0, 20);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t4 no_second_busy %0d", i), busy, 1'b0);
         check($sformatf("t4 no_second_tx %0d", i), TX_OUT, 1'b1);
         @(negedge CLK);
      end

      // Held request: back-to-back frames with one idle cycle between
      run_frame("t5_a", 8'h55, 6'd2, 1'b0, 1'b0, 12'b00_1_01010101_0, 10, 2, 1'b1, -1);
      run_frame("t5_b", 8'h55, 6'd2, 1'b0, 1'b0, 12'b00_1_01010101_0, 10, 2, 1'b1, -1);
      Data_Valid = 1'b0;
      @(negedge CLK);
      check("t5 stop_busy", busy, 1'b0);

      // Asynchronous reset during data bit 3
      P_DATA = 8'hA5; Prescale = 6'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (17) @(negedge CLK);
      check("t6 bit3_tx", TX_OUT, 1'b0);
      check("t6 bit3_busy", busy, 1'b1);
      #2 RST = 1'b0;
      #1;
      check("t6 async_tx", TX_OUT, 1'b1);
      check("t6 async_busy", busy, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      run_frame("t6_81", 8'h81, 6'd4, 1'b1, 1'b0, 12'b0_1_0_10000001_0, 11, 4, 1'b0, -1);

      // Prescale of zero runs as one cycle per bit
      run_frame("t6_p0", 8'h81, 6'd0, 1'b0, 1'b0, 12'b00_1_10000001_0, 10, 1, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
